// File: rtl/popcount_tree_if.sv
// popcount_tree_if
// Bundles the word-in / count-out signals of the pipelined popcount block.
//   A         : word whose set bits are counted (IN_SIZE bits)
//   in_valid  : A carries a word this cycle
//   count     : registered ones-count of a previously sampled word (OUT_SIZE bits)
//   out_valid : count is meaningful this cycle
// The master side produces words and consumes counts; the slave side is the
// popcount block itself.
interface popcount_tree_if #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 5
) ();

  logic [IN_SIZE-1:0]  A;
  logic                in_valid;
  logic [OUT_SIZE-1:0] count;
  logic                out_valid;

  modport master (
    output A,
    output in_valid,
    input  count,
    input  out_valid
  );

  modport slave (
    input  A,
    input  in_valid,
    output count,
    output out_valid
  );

endinterface

// File: rtl/popcount_tree.sv
// popcount_tree
// Pipelined population count. The input word is zero-padded to the next power
// of two and reduced by a binary adder tree, one register stage per tree
// level, so a new word is accepted every clock and its count appears LEVELS
// clocks after the edge that sampled it.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset, clears every pipeline register
//   bus   : popcount_tree_if slave modport (A, in_valid in; count, out_valid out)
module popcount_tree #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  popcount_tree_if.slave bus
);

  // A one-bit word still gets one adder level (pairing the bit with a zero),
  // which gives it the single register stage it needs.
  localparam int LEVELS = (IN_SIZE <= 1) ? 1 : $clog2(IN_SIZE);
  localparam int P      = 1 << LEVELS;

  // Zero padding at the MSB end so the tree is always a full binary tree.
  logic [P-1:0] padded;

  always_comb begin
    padded                = '0;
    padded[IN_SIZE-1:0]   = bus.A;
  end

  // Adder tree. Level k holds P>>k registered partial sums, each k+1 bits
  // wide, which is exactly enough for the largest possible count of the 2^k
  // input bits it covers, so nothing is ever truncated inside the tree.
  // Data registers load every cycle regardless of in_valid; their contents
  // only matter when the matching valid bit emerges at the output.
  genvar k;
  generate
    for (k = 1; k <= LEVELS; k++) begin : g_lvl
      logic [k:0] sum [P>>k];

      if (k == 1) begin : g_leaf
        // First level: add adjacent raw input bits.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < (P >> 1); j++) begin
              sum[j] <= '0;
            end
          end else begin
            for (int j = 0; j < (P >> 1); j++) begin
              sum[j] <= {1'b0, padded[2*j]} + {1'b0, padded[2*j+1]};
            end
          end
        end
      end else begin : g_node
        // Deeper levels: add adjacent sums from the level above, widening
        // by one bit so the carry is kept.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < (P >> k); j++) begin
              sum[j] <= '0;
            end
          end else begin
            for (int j = 0; j < (P >> k); j++) begin
              sum[j] <= {1'b0, g_lvl[k-1].sum[2*j]} + {1'b0, g_lvl[k-1].sum[2*j+1]};
            end
          end
        end
      end
    end
  endgenerate

  // Valid pipeline: one stage per tree level so the flag stays aligned with
  // the data it qualifies. Reset empties it, discarding in-flight words.
  logic [LEVELS-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= bus.in_valid;
      for (int i = 1; i < LEVELS; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // The root sum register drives count directly. The size cast zero-extends
  // when OUT_SIZE is wider than the root and keeps the low bits (count modulo
  // 2^OUT_SIZE) when it is narrower.
  assign bus.out_valid = vld[LEVELS-1];
  assign bus.count     = OUT_SIZE'(g_lvl[LEVELS].sum[0]);

endmodule

// File: tb/tb_popcount_tree.sv
// tb_popcount_tree
// Self-checking bench for popcount_tree. Four instances cover the default
// 16/5 configuration, a truncating 16/4 output, a non-power-of-two 5/3 input
// and the degenerate 1-bit input. Inputs are driven and outputs sampled on the
// falling clock edge; the expected count of every word comes from a plain
// bit-counting model, and latency comes from the instance's tree depth.
module tb_popcount_tree;

  logic clk = 1'b0;
  logic rst_n;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  popcount_tree_if #(.IN_SIZE(16), .OUT_SIZE(5)) b16  ();
  popcount_tree_if #(.IN_SIZE(16), .OUT_SIZE(4)) b16t ();
  popcount_tree_if #(.IN_SIZE(5),  .OUT_SIZE(3)) b5   ();
  popcount_tree_if #(.IN_SIZE(1),  .OUT_SIZE(1)) b1   ();

  popcount_tree #(.IN_SIZE(16), .OUT_SIZE(5)) dut16  (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  popcount_tree #(.IN_SIZE(16), .OUT_SIZE(4)) dut16t (.clk(clk), .rst_n(rst_n), .bus(b16t.slave));
  popcount_tree #(.IN_SIZE(5),  .OUT_SIZE(3)) dut5   (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
  popcount_tree #(.IN_SIZE(1),  .OUT_SIZE(1)) dut1   (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // Reference model: number of set bits among the low n bits of w, reduced
  // modulo 2^outBits.
  function automatic int refCount(input logic [15:0] w, input int n, input int outBits);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (w[i] == 1'b1) c = c + 1;
    end
    return c % (1 << outBits);
  endfunction

  // Reset state of every instance, then release.
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nChecks++;
    if (b16.count !== 5'd0 || b16.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset16: got count=%0d valid=%0b, want 0/0", b16.count, b16.out_valid);
    end
    nChecks++;
    if (b16t.count !== 4'd0 || b16t.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset16t: got count=%0d valid=%0b, want 0/0", b16t.count, b16t.out_valid);
    end
    nChecks++;
    if (b5.count !== 3'd0 || b5.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset5: got count=%0d valid=%0b, want 0/0", b5.count, b5.out_valid);
    end
    nChecks++;
    if (b1.count !== 1'b0 || b1.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset1: got count=%0d valid=%0b, want 0/0", b1.count, b1.out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Individual words, each held for three cycles.
  task automatic test_single_words();
    logic [15:0] w   [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                             16'h0004, 16'h007F, 16'h0080, 16'hFFFF};
    int          req [8] = '{0, 1, 1, 2, 1, 7, 1, 16};
    for (int c = 0; c <= 24 + 4; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 4 && c < 28) begin
        if (b16.out_valid !== 1'b1 || b16.count !== 5'(req[(c-4)/3])) begin
          nFails++;
          $display("[TB] FAIL single[%0d]: got valid=%0b count=%0d, want valid=1 count=%0d",
                   c - 4, b16.out_valid, b16.count, req[(c-4)/3]);
        end
      end else if (b16.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL single_idle[%0d]: got valid=%0b, want 0", c, b16.out_valid);
      end
      if (c < 24) begin
        b16.A = w[c/3];
        b16.in_valid = 1'b1;
      end else begin
        b16.A = 16'($urandom);
        b16.in_valid = 1'b0;
      end
    end
  endtask

  // Back-to-back words produce back-to-back counts.
  task automatic test_back_to_back();
    logic [15:0] w   [5] = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h8001, 16'h7FFE};
    int          req [5] = '{16, 0, 8, 2, 14};
    for (int c = 0; c <= 5 + 4; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 4 && c < 9) begin
        if (b16.out_valid !== 1'b1 || b16.count !== 5'(req[c-4])) begin
          nFails++;
          $display("[TB] FAIL stream[%0d]: got valid=%0b count=%0d, want valid=1 count=%0d",
                   c - 4, b16.out_valid, b16.count, req[c-4]);
        end
      end else if (b16.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL stream_idle[%0d]: got valid=%0b, want 0", c, b16.out_valid);
      end
      if (c < 5) begin
        b16.A = w[c];
        b16.in_valid = 1'b1;
      end else begin
        b16.in_valid = 1'b0;
      end
    end
  endtask

  // A bubble in in_valid shows up as a bubble in out_valid.
  task automatic test_valid_gaps();
    logic [15:0] w   [3] = '{16'h00FF, 16'h1234, 16'h0F0F};
    logic        v   [3] = '{1'b1, 1'b0, 1'b1};
    int          req [3] = '{8, 0, 8};
    for (int c = 0; c <= 3 + 4; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 4 && c < 7) begin
        if (b16.out_valid !== v[c-4] || (v[c-4] && b16.count !== 5'(req[c-4]))) begin
          nFails++;
          $display("[TB] FAIL gaps[%0d]: got valid=%0b count=%0d, want valid=%0b count=%0d",
                   c - 4, b16.out_valid, b16.count, v[c-4], req[c-4]);
        end
      end else if (b16.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL gaps_idle[%0d]: got valid=%0b, want 0", c, b16.out_valid);
      end
      if (c < 3) begin
        b16.A = w[c];
        b16.in_valid = v[c];
      end else begin
        b16.in_valid = 1'b0;
      end
    end
  endtask

  // Random words with random valid bubbles against the reference model.
  task automatic test_random_stream();
    logic [15:0] w [48];
    logic        v [48];
    for (int i = 0; i < 48; i++) begin
      w[i] = 16'($urandom);
      v[i] = ($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c <= 48 + 4; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 4 && c < 52) begin
        if (b16.out_valid !== v[c-4] ||
            (v[c-4] && b16.count !== 5'(refCount(w[c-4], 16, 5)))) begin
          nFails++;
          $display("[TB] FAIL random[%0d] A=%h: got valid=%0b count=%0d, want valid=%0b count=%0d",
                   c - 4, w[c-4], b16.out_valid, b16.count, v[c-4], refCount(w[c-4], 16, 5));
        end
      end else if (b16.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL random_idle[%0d]: got valid=%0b, want 0", c, b16.out_valid);
      end
      if (c < 48) begin
        b16.A = w[c];
        b16.in_valid = v[c];
      end else begin
        b16.in_valid = 1'b0;
      end
    end
  endtask

  // Asynchronous reset with words in flight, then recovery.
  task automatic test_async_reset();
    logic [15:0] w [5] = '{16'h00FF, 16'h0007, 16'h3333, 16'h7777, 16'hFFFF};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      b16.A = w[c];
      b16.in_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    nChecks++;
    if (b16.out_valid !== 1'b1 || b16.count !== 5'(refCount(w[1], 16, 5))) begin
      nFails++;
      $display("[TB] FAIL prereset: got valid=%0b count=%0d, want valid=1 count=%0d",
               b16.out_valid, b16.count, refCount(w[1], 16, 5));
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (b16.out_valid !== 1'b0 || b16.count !== 5'd0) begin
      nFails++;
      $display("[TB] FAIL async_clear: got valid=%0b count=%0d, want 0/0", b16.out_valid, b16.count);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChecks++;
      if (b16.out_valid !== 1'b0 || b16.count !== 5'd0) begin
        nFails++;
        $display("[TB] FAIL reset_hold[%0d]: got valid=%0b count=%0d, want 0/0",
                 c, b16.out_valid, b16.count);
      end
      b16.A = 16'hFFFF;
      b16.in_valid = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    b16.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nChecks++;
      if (b16.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL stale[%0d]: got valid=%0b, want 0", c, b16.out_valid);
      end
    end
    b16.A = 16'h0003;
    b16.in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      b16.in_valid = 1'b0;
      nChecks++;
      if (c == 4) begin
        if (b16.out_valid !== 1'b1 || b16.count !== 5'd2) begin
          nFails++;
          $display("[TB] FAIL post_reset: got valid=%0b count=%0d, want valid=1 count=2",
                   b16.out_valid, b16.count);
        end
      end else if (b16.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL post_reset_idle[%0d]: got valid=%0b, want 0", c, b16.out_valid);
      end
    end
  endtask

  // Narrow output keeps the count modulo 2^OUT_SIZE.
  task automatic test_truncation();
    logic [15:0] w   [2] = '{16'hFFFF, 16'h7FFF};
    int          req [2] = '{0, 15};
    for (int c = 0; c <= 2 + 4; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 4 && c < 6) begin
        if (b16t.out_valid !== 1'b1 || b16t.count !== 4'(req[c-4]) ||
            b16t.count !== 4'(refCount(w[c-4], 16, 4))) begin
          nFails++;
          $display("[TB] FAIL trunc[%0d]: got valid=%0b count=%0d, want valid=1 count=%0d",
                   c - 4, b16t.out_valid, b16t.count, req[c-4]);
        end
      end else if (b16t.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL trunc_idle[%0d]: got valid=%0b, want 0", c, b16t.out_valid);
      end
      if (c < 2) begin
        b16t.A = w[c];
        b16t.in_valid = 1'b1;
      end else begin
        b16t.in_valid = 1'b0;
      end
    end
  endtask

  // Five-bit input: padded tree of depth 3, fixed words then random ones.
  task automatic test_odd_size();
    logic [4:0] w [20];
    w[0] = 5'b11111;
    w[1] = 5'b10100;
    for (int i = 2; i < 20; i++) w[i] = 5'($urandom);
    for (int c = 0; c <= 20 + 3; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 3 && c < 23) begin
        if (b5.out_valid !== 1'b1 || b5.count !== 3'(refCount(16'(w[c-3]), 5, 3))) begin
          nFails++;
          $display("[TB] FAIL odd[%0d] A=%b: got valid=%0b count=%0d, want valid=1 count=%0d",
                   c - 3, w[c-3], b5.out_valid, b5.count, refCount(16'(w[c-3]), 5, 3));
        end
      end else if (b5.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL odd_idle[%0d]: got valid=%0b, want 0", c, b5.out_valid);
      end
      if (c < 20) begin
        b5.A = w[c];
        b5.in_valid = 1'b1;
      end else begin
        b5.in_valid = 1'b0;
      end
    end
  endtask

  // One-bit input: single register stage.
  task automatic test_single_bit();
    logic w [3] = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c <= 3 + 1; c++) begin
      @(negedge clk);
      nChecks++;
      if (c >= 1 && c < 4) begin
        if (b1.out_valid !== 1'b1 || b1.count !== w[c-1]) begin
          nFails++;
          $display("[TB] FAIL bit[%0d]: got valid=%0b count=%0d, want valid=1 count=%0d",
                   c - 1, b1.out_valid, b1.count, w[c-1]);
        end
      end else if (b1.out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL bit_idle[%0d]: got valid=%0b, want 0", c, b1.out_valid);
      end
      if (c < 3) begin
        b1.A = w[c];
        b1.in_valid = 1'b1;
      end else begin
        b1.in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b16.A  = '0;  b16.in_valid  = 1'b0;
    b16t.A = '0;  b16t.in_valid = 1'b0;
    b5.A   = '0;  b5.in_valid   = 1'b0;
    b1.A   = '0;  b1.in_valid   = 1'b0;

    $display("[TB] starting popcount_tree checks");
    test_reset();
    test_single_words();
    test_back_to_back();
    test_valid_gaps();
    test_random_stream();
    test_async_reset();
    test_truncation();
    test_odd_size();
    test_single_bit();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/popcount_tree.md
# popcount_tree

Pipelined population-count block: it counts the number of set bits in an IN_SIZE-bit input word and presents the count as an OUT_SIZE-bit unsigned result. It is built as a binary adder tree with one register stage per tree level, giving one result per clock at full throughput. It is a datapath leaf used wherever a ones-count of a bit vector is needed, for example in bit-manipulation and Hamming-weight logic.

## Interface
- IN_SIZE, default 16: input word width in bits, ≥1.
- OUT_SIZE, default 5: result width in bits; ≥1; clog2(IN_SIZE+1) gives an exact count.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- A  input  IN_SIZE  word to count; sampled only when in_valid=1.
- in_valid  input  1  A carries a word this cycle.
- count  output  OUT_SIZE  number of 1 bits in the sampled A, registered.
- out_valid  output  1  count is valid this cycle.

## Operation
- Define LEVELS = clog2(IN_SIZE), with a minimum of 1. Pad A with zeros at the MSB end up to P = 2^LEVELS bits.
- Level 1 adds adjacent bit pairs, giving P/2 partial sums of 2 bits each.
- Level k adds adjacent level-(k−1) sums, giving P/2^k sums of k+1 bits each. Full width is kept at every level; no truncation occurs inside the tree.
- Each level's sums are registered. The final-level sum, LEVELS+1 bits wide, drives count.
- Output width rule:
  - If OUT_SIZE ≥ LEVELS+1, count is zero-extended.
  - Otherwise count is the low OUT_SIZE bits of the sum, i.e. the true count mod 2^OUT_SIZE.
- IN_SIZE=1: count = A[0], zero-extended, after a single register stage.
- Valid handling:
  - in_valid travels through a LEVELS-deep shift register alongside the data, and the last stage drives out_valid.
  - When in_valid=0, data registers still load, so their contents are don't-care. count must be ignored while out_valid=0.
- No backpressure and no stall: a new word is accepted every cycle.
- The block computes the count of each word independently. It holds no accumulation state across words.

## Timing
- Latency is LEVELS cycles from the edge that samples A with in_valid=1 to count/out_valid being valid. For IN_SIZE=16 this is 4 cycles.
- Throughput: 1 word per cycle. Back-to-back inputs produce back-to-back outputs in order.
- Reset (rst_n=0), asynchronous and immediate, regardless of clk:
  - Every pipeline register, valid stage, count and out_valid clear to 0.
  - While held, outputs stay at 0 and in_valid is ignored.
- Reset mid-operation: all in-flight words are discarded, with no output for them.
- Reset release: after rst_n rises, the first word sampled at a rising edge appears LEVELS cycles later.
- No combinational path from A or in_valid to any output.

## Test plan
1. IN_SIZE=16, OUT_SIZE=5: apply A = 0, 1, 2, 3, 4, 127, 128, 0xFFFF, each with in_valid=1 and each held several cycles. Required count = 0, 1, 1, 2, 1, 7, 1, 16, each appearing 4 cycles after sampling with out_valid=1.
2. Streaming: in consecutive cycles apply A = 0xFFFF, 0x0000, 0xAAAA, 0x8001, 0x7FFE. Required count on consecutive cycles starting at latency 4 = 16, 0, 8, 2, 14, with out_valid held at 1.
3. Valid gaps: apply in_valid pattern 1,0,1 with A = 0x00FF, 0x1234, 0x0F0F. Required out_valid pattern 1,0,1, with counts 8 and 8 in the valid cycles.
4. Reset: assert rst_n=0 asynchronously (between clock edges) while 3 words are in flight. count=0 and out_valid=0 must follow immediately. After release, no stale outputs appear; the next word A=0x0003 gives count=2 after 4 cycles.
5. Truncation: with IN_SIZE=16, OUT_SIZE=4, A=0xFFFF → count=0; A=0x7FFF → count=15.
6. Non-power-of-two and degenerate sizes:
   - IN_SIZE=5, OUT_SIZE=3: A=5'b11111 → count=5 with latency 3; A=5'b10100 → count=2.
   - IN_SIZE=1: A=1 → count=1 after 1 cycle.
